anim_frame_sequencer: RTL and testbench



---
 rtl/anim_frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_anim_frame_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer: frame index sequencer for the 7-segment animation engine.
// Holds the last-frame table, divides clk into frame ticks, steps the frame index.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   ena           - 1 = prescaler and frame advance run
//   tick_div      - frame period is tick_div+1 clk cycles
//   animation     - requested animation index
//   mode          - 00 loop, 01 ping-pong, 10 one-shot, 11 pause
//   restart       - 1-cycle pulse, rewinds the current animation
//   animation_q   - animation currently playing
//   limit         - last frame index of animation_q
//   frame         - current frame index, 0..limit
//   frame_strobe  - high in the cycle frame holds a new value
//   done          - sticky one-shot completion flag
module anim_frame_sequencer #(
    parameter int ANI_W      = 6,
    parameter int FRAME_W    = 5,
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] tick_div,
    input  logic [ANI_W-1:0]      animation,
    input  logic [1:0]            mode,
    input  logic                  restart,
    output logic [ANI_W-1:0]      animation_q,
    output logic [FRAME_W-1:0]    limit,
    output logic [FRAME_W-1:0]    frame,
    output logic                  frame_strobe,
    output logic                  done
);

    localparam logic [1:0] MODE_LOOP  = 2'b00;
    localparam logic [1:0] MODE_PING  = 2'b01;
    localparam logic [1:0] MODE_ONE   = 2'b10;
    localparam logic [1:0] MODE_PAUSE = 2'b11;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Last-frame table, indexed by animation number.
    function automatic logic [FRAME_W-1:0] lut_limit(
        input logic [ANI_W-1:0] a
    );
        int unsigned idx;
        logic [4:0]  r;
        idx = 32'(a);
        case (idx) inside
            0:        r = 5'd9;
            1:        r = 5'd11;
            [2:6]:    r = 5'd5;
            7:        r = 5'd1;
            [8:9]:    r = 5'd3;
            [10:14]:  r = 5'd1;
            15:       r = 5'd3;
            16:       r = 5'd4;
            17:       r = 5'd1;
            [18:22]:  r = 5'd6;
            23:       r = 5'd3;
            [24:27]:  r = 5'd15;
            28:       r = 5'd31;
            29:       r = 5'd3;
            30:       r = 5'd10;
            31:       r = 5'd31;
            32:       r = 5'd4;
            33:       r = 5'd8;
            default:  r = 5'd0;
        endcase
        return FRAME_W'(r);
    endfunction

    logic [ANI_W-1:0]      animation_d;
    logic [FRAME_W-1:0]    limit_q, limit_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    dir_e                  dir_q, dir_d;
    logic                  done_q, done_d;
    logic                  strobe_q, strobe_d;
    logic [ANI_W-1:0]      ani_q;

    logic change;
    logic run;
    logic tick;

    assign change = (animation != ani_q) || restart;
    assign run    = ena && (mode != MODE_PAUSE);
    // >= rather than == so a tick_div lowered below the running
    // count still produces a tick and wraps the count.
    assign tick   = run && (cnt_q >= tick_div);

    always_comb begin
        animation_d = ani_q;
        limit_d     = limit_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        done_d      = done_q;
        strobe_d    = 1'b0;

        if (change) begin
            animation_d = animation;
            limit_d     = lut_limit(animation);
            frame_d     = '0;
            cnt_d       = '0;
            dir_d       = DIR_UP;
            done_d      = 1'b0;
        end else begin
            if (run) begin
                cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
            end

            if (tick) begin
                case (mode)
                    MODE_LOOP: begin
                        strobe_d = 1'b1;
                        frame_d  = (frame_q == limit_q) ? '0
                                 : frame_q + FRAME_W'(1);
                    end
                    MODE_PING: begin
                        strobe_d = 1'b1;
                        if (limit_q == '0) begin
                            frame_d = '0;
                            dir_d   = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            if (frame_q == limit_q) begin
                                dir_d   = DIR_DN;
                                frame_d = frame_q - FRAME_W'(1);
                            end else begin
                                frame_d = frame_q + FRAME_W'(1);
                            end
                        end else begin
                            if (frame_q == '0) begin
                                dir_d   = DIR_UP;
                                frame_d = frame_q + FRAME_W'(1);
                            end else begin
                                frame_d = frame_q - FRAME_W'(1);
                            end
                        end
                    end
                    MODE_ONE: begin
                        if (frame_q < limit_q) begin
                            strobe_d = 1'b1;
                            frame_d  = frame_q + FRAME_W'(1);
                            if (frame_d == limit_q) begin
                                done_d = 1'b1;
                            end
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                    MODE_PAUSE: begin
                        frame_d = frame_q;
                    end
                    default: begin
                        frame_d = frame_q;
                    end
                endcase
            end

            // Only ping-pong uses a downward direction; pause keeps
            // done so a finished one-shot stays visible while paused.
            if (mode != MODE_PING) begin
                dir_d = DIR_UP;
            end
            if ((mode == MODE_LOOP) || (mode == MODE_PING)) begin
                done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ani_q    <= '0;
            limit_q  <= lut_limit('0);
            frame_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            ani_q    <= animation_d;
            limit_q  <= limit_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign animation_q  = ani_q;
    assign limit        = limit_q;
    assign frame        = frame_q;
    assign frame_strobe = strobe_q;
    assign done         = done_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// tb_anim_frame_sequencer: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural model of the frame sequencer.
module tb_anim_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic [23:0] tick_div;
    logic [5:0]  animation;
    logic [1:0]  mode;
    logic        restart;
    logic [5:0]  animation_q;
    logic [4:0]  limit;
    logic [4:0]  frame;
    logic        frame_strobe;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    anim_frame_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .tick_div     (tick_div),
        .animation    (animation),
        .mode         (mode),
        .restart      (restart),
        .animation_q  (animation_q),
        .limit        (limit),
        .frame        (frame),
        .frame_strobe (frame_strobe),
        .done         (done)
    );

    // Behavioural model state
    int tab [64];
    int m_ani, m_lim, m_frame, m_cnt;
    bit m_up, m_done, m_stb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic build_table();
        for (int i = 0; i < 64; i++) tab[i] = 0;
        tab[0] = 9; tab[1] = 11;
        for (int i = 2; i <= 6; i++) tab[i] = 5;
        tab[7] = 1; tab[8] = 3; tab[9] = 3;
        for (int i = 10; i <= 14; i++) tab[i] = 1;
        tab[15] = 3; tab[16] = 4; tab[17] = 1;
        for (int i = 18; i <= 22; i++) tab[i] = 6;
        tab[23] = 3;
        for (int i = 24; i <= 27; i++) tab[i] = 15;
        tab[28] = 31; tab[29] = 3; tab[30] = 10; tab[31] = 31;
        tab[32] = 4; tab[33] = 8;
    endtask

    task automatic model_step();
        bit tk;
        if (reset) begin
            m_ani = 0; m_lim = tab[0]; m_frame = 0; m_cnt = 0;
            m_up = 1; m_done = 0; m_stb = 0;
            return;
        end
        if (int'(animation) != m_ani || restart) begin
            m_ani = int'(animation); m_lim = tab[m_ani];
            m_frame = 0; m_cnt = 0; m_up = 1; m_done = 0; m_stb = 0;
            return;
        end
        m_stb = 0;
        if (ena && mode != 2'd3) begin
            tk = (m_cnt >= int'(tick_div));
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                if (mode == 2'd0) begin
                    m_frame = (m_frame + 1) % (m_lim + 1);
                    m_stb = 1;
                end else if (mode == 2'd1) begin
                    m_stb = 1;
                    if (m_lim == 0) m_frame = 0;
                    else if (m_up) begin
                        if (m_frame < m_lim) m_frame++;
                        else begin m_up = 0; m_frame--; end
                    end else begin
                        if (m_frame > 0) m_frame--;
                        else begin m_up = 1; m_frame++; end
                    end
                end else begin
                    if (m_frame < m_lim) begin
                        m_frame++; m_stb = 1;
                        if (m_frame == m_lim) m_done = 1;
                    end else m_done = 1;
                end
            end
        end
        if (mode != 2'd1) m_up = 1;
        if (mode == 2'd0 || mode == 2'd1) m_done = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("animation_q", 32'(animation_q), 32'(m_ani));
        chk("limit", 32'(limit), 32'(m_lim));
        chk("frame", 32'(frame), 32'(m_frame));
        chk("frame_strobe", 32'(frame_strobe), 32'(m_stb));
        chk("done", 32'(done), 32'(m_done));
    endtask

    int exp2 [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    bit hit;

    initial begin
        build_table();
        reset = 1; ena = 1; tick_div = '0; animation = '0;
        mode = 2'd0; restart = 0;

        // 1: reset, loop animation 0 every cycle
        cyc();
        chk("rst_limit", 32'(limit), 32'd9);
        chk("rst_frame", 32'(frame), 32'd0);
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("s1_frame", 32'(frame), 32'((i + 1) % 10));
        end

        // 2: ping-pong animation 2
        animation = 6'd2; mode = 2'd1;
        cyc();
        chk("s2_limit", 32'(limit), 32'd5);
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk("s2_frame", 32'(frame), 32'(exp2[i]));
        end

        // 3: one-shot animation 7, period 4
        animation = 6'd7; mode = 2'd2; tick_div = 24'd3;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        chk("s3_frame", 32'(frame), 32'd1);
        chk("s3_done", 32'(done), 32'd1);
        for (int i = 0; i < 10; i++) cyc();
        restart = 1;
        cyc();
        restart = 0;
        chk("s3_rst_frame", 32'(frame), 32'd0);
        chk("s3_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) cyc();

        // 4: switch animation on a tick edge mid-loop
        animation = 6'd28; mode = 2'd0; tick_div = 24'd2;
        cyc();
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_frame == 17 && m_cnt >= int'(tick_div)) hit = 1;
            else cyc();
        end
        chk("s4_reach", 32'(hit), 32'd1);
        animation = 6'd1;
        cyc();
        chk("s4_limit", 32'(limit), 32'd11);
        chk("s4_frame", 32'(frame), 32'd0);
        chk("s4_strobe", 32'(frame_strobe), 32'd0);
        for (int i = 0; i < 6; i++) cyc();

        // 5: animation without table entry, then pause and ena=0
        animation = 6'd50; tick_div = 24'd1;
        for (int i = 0; i < 6; i++) cyc();
        chk("s5_limit", 32'(limit), 32'd0);
        mode = 2'd3;
        for (int i = 0; i < 4; i++) cyc();
        mode = 2'd0; ena = 0;
        for (int i = 0; i < 4; i++) cyc();
        ena = 1;

        // 6: reset during ping-pong downswing
        animation = 6'd2; mode = 2'd1; tick_div = 24'd0;
        for (int i = 0; i < 9; i++) cyc();
        reset = 1;
        cyc();
        reset = 0; animation = 6'd0; mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s6_frame", 32'(frame), 32'(i + 1));
        end

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0)
                animation = ($urandom_range(0, 3) == 0) ?
                    6'($urandom_range(0, 63)) : 6'($urandom_range(0, 33));
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0)
                tick_div = 24'($urandom_range(0, 4));
            reset = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
